weighted_rr_arbiter: RTL

WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

---
 rtl/arb_pkg.sv | 15 +
 rtl/priority_encoder.sv | 27 ++
 rtl/weighted_rr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM state encoding
// and the credit-reload helper.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // A zero weight still buys one transfer so a requester can never starve itself.
  function automatic logic [31:0] credit_reload(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the winning bit (lowest index wins when LSB_HIGH is nonzero, else highest).
module priority_encoder #(
  parameter int WIDTH    = 4,
  parameter int LSB_HIGH = 1,
  parameter int IDX_W    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    if (LSB_HIGH != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) index = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i]) index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with per-port burst credits.
// Optional forced release on ack starvation when WRR_GRANT_TIMEOUT_EN is defined.
//
// state     | meaning
// ARB_IDLE  | no grant outstanding
// ARB_GRANT | one port holds the grant and spends credits on its acks
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int PORTS                 = 4,
  parameter int WEIGHT_W              = 4,
  parameter int ARB_LSB_HIGH_PRIORITY = 0,
  parameter int TIMEOUT               = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            request,
  input  logic [PORTS-1:0]            acknowledge,
  input  logic [PORTS*WEIGHT_W-1:0]   weight,
  output logic [PORTS-1:0]            grant,
  output logic                        grant_valid,
  output logic [$clog2(PORTS)-1:0]    grant_encoded,
  output logic [WEIGHT_W-1:0]         credit,
  output logic                        timeout
);

  localparam int IDX_W = $clog2(PORTS);

  if (PORTS < 2 || PORTS > 32) begin : g_bad_ports
    $error("weighted_rr_arbiter: PORTS must be 2..32");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("weighted_rr_arbiter: TIMEOUT must be 1..255");
  end

  arb_state_t         state, state_nxt;
  logic [PORTS-1:0]   mask, mask_nxt;
  logic [PORTS-1:0]   grant_nxt;
  logic [IDX_W-1:0]   enc_nxt;
  logic [WEIGHT_W-1:0] credit_nxt;

  logic               any_req, m_valid, ack_k, req_k, release_now, load, to_expired;
  logic [IDX_W-1:0]   u_idx, m_idx, pick;

  priority_encoder #(
    .WIDTH   (PORTS),
    .LSB_HIGH(ARB_LSB_HIGH_PRIORITY),
    .IDX_W   (IDX_W)
  ) u_pe_unmasked (
    .req  (request),
    .valid(any_req),
    .index(u_idx)
  );

  priority_encoder #(
    .WIDTH   (PORTS),
    .LSB_HIGH(ARB_LSB_HIGH_PRIORITY),
    .IDX_W   (IDX_W)
  ) u_pe_masked (
    .req  (request & mask),
    .valid(m_valid),
    .index(m_idx)
  );

  // Ports that follow k in round-robin order.
  function automatic logic [PORTS-1:0] rr_mask(input logic [IDX_W-1:0] k);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < PORTS; i++) begin
      m[i] = (ARB_LSB_HIGH_PRIORITY != 0) ? (IDX_W'(i) > k) : (IDX_W'(i) < k);
    end
    return m;
  endfunction

  assign pick        = m_valid ? m_idx : u_idx;
  assign ack_k       = acknowledge[grant_encoded];
  assign req_k       = request[grant_encoded];
  assign release_now = (ack_k && credit == WEIGHT_W'(1)) || !req_k || to_expired;
  assign grant_valid = |grant;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    enc_nxt    = grant_encoded;
    credit_nxt = credit;
    mask_nxt   = mask;
    load       = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) load = 1'b1;
      end
      ARB_GRANT: begin
        if (release_now) begin
          if (any_req) begin
            load = 1'b1;
          end else begin
            state_nxt  = ARB_IDLE;
            grant_nxt  = '0;
            enc_nxt    = '0;
            credit_nxt = '0;
          end
        end else if (ack_k) begin
          credit_nxt = credit - WEIGHT_W'(1);
        end
      end
    endcase
    if (load) begin
      state_nxt       = ARB_GRANT;
      grant_nxt       = '0;
      grant_nxt[pick] = 1'b1;
      enc_nxt         = pick;
      credit_nxt      = WEIGHT_W'(credit_reload(32'(weight[pick*WEIGHT_W +: WEIGHT_W])));
      mask_nxt        = rr_mask(pick);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      grant_encoded <= '0;
      credit        <= '0;
      mask          <= '0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      grant_encoded <= enc_nxt;
      credit        <= credit_nxt;
      mask          <= mask_nxt;
    end
  end

`ifdef WRR_GRANT_TIMEOUT_EN
  logic [7:0] to_cnt, to_cnt_nxt;
  logic       timeout_q;

  // Counter reaching TIMEOUT raises the pulse; the release follows in that same cycle.
  assign to_expired = (state == ARB_GRANT) && (to_cnt == 8'(TIMEOUT));

  always_comb begin
    to_cnt_nxt = '0;
    if (state == ARB_GRANT && !release_now && !ack_k) to_cnt_nxt = to_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt    <= to_cnt_nxt;
      timeout_q <= (to_cnt_nxt == 8'(TIMEOUT));
    end
  end

  assign timeout = timeout_q;
`else
  assign to_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule
